// File: rtl/dq_pkg.sv
// Shared types and helpers for the dequant scale sequencer.
// Holds the FSM state enum, beat-count derivation and counter-width helper.
package dq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SCALE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } dq_seq_state_t;

    localparam int DQ_LANES_NUM = 16;
    localparam int DQ_ELEMS     = 256;

    function automatic int dq_beats(input int elems, input int lanes);
        return elems / lanes;
    endfunction

    // Never returns less than 1 so a single-beat tile still gets a legal counter.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    localparam int DQ_BEATS = dq_beats(DQ_ELEMS, DQ_LANES_NUM);

endpackage

// File: rtl/dq_scale_sequencer.sv
// Pops one scale tile, pulses the shift-register load, then steps once per accepted beat.
// Latency: one WAIT_SCALE plus one LOAD bubble per tile; beat handshake is combinational.
// Backpressure: beats held off (ready=0) outside RUN; optional stall counter under DQ_SEQ_PERF_EN.
module dq_scale_sequencer
    import dq_pkg::*;
#(
    parameter int LANES_NUM  = 16,
    parameter int ELEMS      = 256,
    parameter int TILE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  start_i,
    input  logic [TILE_CNT_W-1:0] cfg_tiles_i,
    input  logic                  abort_i,
    input  logic                  scale_empty_i,
    output logic                  scale_pop_o,
    output logic                  dq_start_o,
    output logic                  dq_step_o,
    input  logic                  acc_valid_i,
    output logic                  acc_ready_o,
    input  logic                  dq_ready_i,
    output logic                  dq_valid_o,
    output logic                  dq_last_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef DQ_SEQ_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int BEATS = dq_beats(ELEMS, LANES_NUM);
    localparam int BCW   = clog2(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    dq_seq_state_t         state;
    dq_seq_state_t         state_nxt;
    logic [BCW-1:0]        beat_cnt;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic [TILE_CNT_W-1:0] tile_inc;
    logic [TILE_CNT_W-1:0] cfg_tiles;
    logic                  in_run;
    logic                  xfer;
    logic                  beat_last;
    logic                  start_acc;

    assign in_run    = (state == ST_RUN);
    assign xfer      = in_run & acc_valid_i & dq_ready_i;
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign tile_inc  = tile_cnt + TILE_CNT_W'(1);
    assign start_acc = (state == ST_IDLE) & start_i & ~abort_i;

    assign dq_start_o  = (state == ST_LOAD);
    assign scale_pop_o = dq_start_o;
    assign dq_step_o   = xfer;
    assign acc_ready_o = in_run & dq_ready_i;
    assign dq_valid_o  = in_run & acc_valid_i;
    assign dq_last_o   = in_run & beat_last;
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = (cfg_tiles_i == '0) ? ST_DONE : ST_WAIT_SCALE;
                end
            end
            ST_WAIT_SCALE: begin
                if (!scale_empty_i) begin
                    state_nxt = ST_LOAD;
                end
            end
            // Shift register's low bundle is only valid the cycle after the load.
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                if (xfer && beat_last) begin
                    state_nxt = (tile_inc == cfg_tiles) ? ST_DONE : ST_WAIT_SCALE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            beat_cnt  <= '0;
            tile_cnt  <= '0;
            cfg_tiles <= '0;
        end else if (abort_i) begin
            beat_cnt <= '0;
            tile_cnt <= '0;
        end else if (start_acc) begin
            cfg_tiles <= cfg_tiles_i;
            beat_cnt  <= '0;
            tile_cnt  <= '0;
        end else if (xfer) begin
            if (beat_last) begin
                beat_cnt <= '0;
                tile_cnt <= tile_inc;
            end else begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

`ifdef DQ_SEQ_PERF_EN
    // Counts only cycles actually starved of a scale tile.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            stall_cnt_o <= '0;
        end else if (start_acc) begin
            stall_cnt_o <= '0;
        end else if ((state == ST_WAIT_SCALE) && scale_empty_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dq_scale_sequencer.sv
// Directed bench for dq_scale_sequencer; stall counter checked only when DQ_SEQ_PERF_EN is defined.
module tb_dq_scale_sequencer;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] cfg_tiles_i = '0;
    logic        abort_i = 1'b0;
    logic        scale_empty_i = 1'b0;
    logic        scale_pop_o;
    logic        dq_start_o;
    logic        dq_step_o;
    logic        acc_valid_i = 1'b0;
    logic        acc_ready_o;
    logic        dq_ready_i = 1'b0;
    logic        dq_valid_o;
    logic        dq_last_o;
    logic        busy_o;
    logic        done_o;
`ifdef DQ_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int pops, steps, xfers, lasts, bad, stallc;
    int first_step, last_step, pop_cyc, done_cyc, mbeat, done_seen;

    dq_scale_sequencer dut (
        .clk          (clk),
        .rstnn        (rstnn),
        .start_i      (start_i),
        .cfg_tiles_i  (cfg_tiles_i),
        .abort_i      (abort_i),
        .scale_empty_i(scale_empty_i),
        .scale_pop_o  (scale_pop_o),
        .dq_start_o   (dq_start_o),
        .dq_step_o    (dq_step_o),
        .acc_valid_i  (acc_valid_i),
        .acc_ready_o  (acc_ready_o),
        .dq_ready_i   (dq_ready_i),
        .dq_valid_o   (dq_valid_o),
        .dq_last_o    (dq_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef DQ_SEQ_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] cfg);
        start_i     = 1'b1;
        cfg_tiles_i = cfg;
        @(negedge clk);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Runs cycles after a start until done_o or the budget runs out, collecting counts.
    task automatic run(input int maxc, input bit rnd, input int stall_tile,
                       input int stall_len, input int poke_cyc);
        int   hold;
        logic xfer;
        hold = 0;
        pops = 0; steps = 0; xfers = 0; lasts = 0; bad = 0; stallc = 0;
        first_step = -1; last_step = -1; pop_cyc = -1; done_cyc = -1; mbeat = 0;
        for (int c = 1; c <= maxc; c++) begin
            acc_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dq_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i     = (c == poke_cyc);
            if (c == poke_cyc) cfg_tiles_i = 16'd3;
            if (hold > 0) begin
                scale_empty_i = 1'b1;
                hold--;
            end else begin
                scale_empty_i = 1'b0;
            end
            @(negedge clk);
            if (scale_empty_i && busy_o && !acc_ready_o) stallc++;
            if (scale_pop_o) begin pops++; pop_cyc = c; end
            xfer = dq_valid_o & dq_ready_i;
            if (dq_step_o !== xfer) bad++;
            if (dq_start_o && dq_step_o) bad++;
            if (dq_valid_o && (dq_last_o !== (mbeat == 15))) bad++;
            if (dq_step_o) begin
                steps++;
                if (first_step < 0) first_step = c;
                last_step = c;
            end
            if (xfer) begin
                xfers++;
                if (mbeat == 15) begin
                    lasts++;
                    if (pops == stall_tile) hold = stall_len;
                end
                mbeat = (mbeat + 1) % 16;
            end
            if (done_o) done_cyc = c;
            @(posedge clk);
            #1;
            if (done_cyc > 0) break;
        end
        start_i = 1'b0; acc_valid_i = 1'b0; dq_ready_i = 1'b0; scale_empty_i = 1'b0;
    endtask

    initial begin
        // Reset state, with inputs that would otherwise raise handshakes.
        acc_valid_i = 1'b1;
        dq_ready_i  = 1'b1;
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_acc_ready", acc_ready_o, 0);
        chk("rst_dq_valid", dq_valid_o, 0);
        chk("rst_pop", scale_pop_o, 0);
        chk("rst_step", dq_step_o, 0);
        #4 rstnn = 1'b1;
        @(posedge clk);
        #1;

        // 1: single tile, no backpressure.
        do_start(16'd1);
        run(100, 1'b0, 0, 0, 0);
        chk("t1_pops", pops, 1);
        chk("t1_pop_cyc", pop_cyc, 2);
        chk("t1_first_step", first_step, 3);
        chk("t1_last_step", last_step, 18);
        chk("t1_steps", steps, 16);
        chk("t1_lasts", lasts, 1);
        chk("t1_done_cyc", done_cyc, 19);
        chk("t1_bad", bad, 0);
        @(negedge clk);
        chk("t1_done_one_cycle", done_o, 0);
        chk("t1_idle", busy_o, 0);
        @(posedge clk); #1;

        // 2: three tiles, scale FIFO empty 5 cycles before tile 2.
        do_start(16'd3);
        run(300, 1'b0, 1, 5, 0);
        chk("t2_pops", pops, 3);
        chk("t2_steps", steps, 48);
        chk("t2_stall_cycles", stallc, 5);
        chk("t2_lasts", lasts, 3);
        chk("t2_done_cyc", done_cyc, 60);
        chk("t2_bad", bad, 0);
`ifdef DQ_SEQ_PERF_EN
        chk("t2_stall_cnt", stall_cnt, 5);
        @(posedge clk); #1;
        chk("t2_stall_cnt_hold", stall_cnt, 5);
`endif

        // 3: random 50% backpressure on both sides.
        do_start(16'd2);
        run(1000, 1'b1, 0, 0, 0);
        chk("t3_pops", pops, 2);
        chk("t3_steps", steps, 32);
        chk("t3_xfers", xfers, 32);
        chk("t3_lasts", lasts, 2);
        chk("t3_bad", bad, 0);
        chk("t3_done_seen", done_cyc > 0, 1);

        // 4: zero tiles, then a start during busy that must be ignored.
        do_start(16'd0);
        run(20, 1'b0, 0, 0, 0);
        chk("t4_zero_done_cyc", done_cyc, 1);
        chk("t4_zero_pops", pops, 0);
        chk("t4_zero_steps", steps, 0);
        do_start(16'd1);
        run(100, 1'b0, 0, 0, 5);
        chk("t4_poke_done_cyc", done_cyc, 19);
        chk("t4_poke_pops", pops, 1);
        chk("t4_poke_steps", steps, 16);

        // 5: abort at beat 7 of the first of two tiles.
        do_start(16'd2);
        acc_valid_i = 1'b1;
        dq_ready_i  = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        abort_i = 1'b1;
        @(negedge clk);
        chk("t5_abort_step", dq_step_o, 1);
        chk("t5_abort_last", dq_last_o, 0);
        @(posedge clk); #1;
        abort_i = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy_o, 0);
        chk("t5_acc_ready", acc_ready_o, 0);
        chk("t5_dq_valid", dq_valid_o, 0);
        chk("t5_step", dq_step_o, 0);
        chk("t5_pop", scale_pop_o, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) done_seen++;
            @(negedge clk);
        end
        chk("t5_no_done", done_seen, 0);
        acc_valid_i = 1'b0;
        dq_ready_i  = 1'b0;
        @(posedge clk); #1;
        do_start(16'd1);
        run(100, 1'b0, 0, 0, 0);
        chk("t5_rerun_done_cyc", done_cyc, 19);
        chk("t5_rerun_steps", steps, 16);
        chk("t5_rerun_lasts", lasts, 1);
        chk("t5_rerun_bad", bad, 0);

        // 6: asynchronous reset in the middle of RUN.
        do_start(16'd1);
        acc_valid_i = 1'b1;
        dq_ready_i  = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rstnn = 1'b0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_acc_ready", acc_ready_o, 0);
        chk("t6_dq_valid", dq_valid_o, 0);
        chk("t6_step", dq_step_o, 0);
        chk("t6_pop", scale_pop_o, 0);
        chk("t6_last", dq_last_o, 0);
        chk("t6_done", done_o, 0);
        #3 rstnn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_post_busy", busy_o, 0);
        chk("t6_post_acc_ready", acc_ready_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
